// File: rtl/updn_ctr_p.sv
// Parametrised up/down counter with modulus MAX+1, wrap or saturate at the
// limits, synchronous clear and clamped load, terminal-count pulse and sticky overflow.
module updn_ctr_p #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned MAX   = (2 ** WIDTH) - 1,
   parameter bit          SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cn,
   input  logic             ct,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] op,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_CLR,
      ACT_LOAD,
      ACT_COUNT
   } act_e;

   act_e             act;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] op_nxt;
   logic             tc_nxt;
   logic             ovf_nxt;
   logic             at_max;
   logic             at_zero;
   logic             limit_hit;

   // A full-range modulus can never see an out-of-range load, so skip the clamp.
   generate
      if (MAX >= (2 ** WIDTH) - 1) begin : g_no_clamp
         assign load_val = din;
      end else begin : g_clamp
         assign load_val = (din > MAX_V) ? MAX_V : din;
      end
   endgenerate

   assign at_max    = (op == MAX_V);
   assign at_zero   = (op == '0);
   assign limit_hit = ct ? at_zero : at_max;

   always_comb begin
      if (clr)       act = ACT_CLR;
      else if (ld)   act = ACT_LOAD;
      else if (cn)   act = ACT_COUNT;
      else           act = ACT_HOLD;
   end

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      op_nxt  = op;
      tc_nxt  = 1'b0;
      ovf_nxt = ovf;
      unique case (act)
         ACT_CLR: begin
            op_nxt  = '0;
            ovf_nxt = 1'b0;
         end
         ACT_LOAD: begin
            op_nxt = load_val;
         end
         ACT_COUNT: begin
            if (limit_hit) begin
               tc_nxt  = 1'b1;
               ovf_nxt = 1'b1;
               if (SAT)     op_nxt = op;
               else if (ct) op_nxt = MAX_V;
               else         op_nxt = '0;
            end else if (ct) begin
               op_nxt = op - WIDTH'(1);
            end else begin
               op_nxt = op + WIDTH'(1);
            end
         end
         default: begin
            op_nxt = op;
         end
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op  <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         op  <= op_nxt;
         tc  <= tc_nxt;
         ovf <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_updn_ctr_p.sv
// Bench for updn_ctr_p: five instances share one stimulus stream; directed tables,
// hand-written corner sequences and a random regression against a behavioural model.
module tb_updn_ctr_p;

   logic       clk;
   logic       rst;
   logic       cn, ct, clr, ld;
   logic [7:0] din;

   logic [4:0] op_a, op_b, op_c;
   logic [7:0] op_d, op_e;
   logic       tc_a, tc_b, tc_c, tc_d, tc_e;
   logic       ovf_a, ovf_b, ovf_c, ovf_d, ovf_e;

   int tests = 0;
   int fails = 0;

   // a: 5b wrap full range, b: 5b mod 10 saturate, c: 5b mod 10 wrap,
   // d: 8b wrap full range, e: 8b mod 201 saturate
   updn_ctr_p #(.WIDTH(5), .MAX(31),  .SAT(1'b0)) u_a (.clk(clk), .rst(rst), .cn(cn), .ct(ct),
      .clr(clr), .ld(ld), .din(din[4:0]), .op(op_a), .tc(tc_a), .ovf(ovf_a));
   updn_ctr_p #(.WIDTH(5), .MAX(9),   .SAT(1'b1)) u_b (.clk(clk), .rst(rst), .cn(cn), .ct(ct),
      .clr(clr), .ld(ld), .din(din[4:0]), .op(op_b), .tc(tc_b), .ovf(ovf_b));
   updn_ctr_p #(.WIDTH(5), .MAX(9),   .SAT(1'b0)) u_c (.clk(clk), .rst(rst), .cn(cn), .ct(ct),
      .clr(clr), .ld(ld), .din(din[4:0]), .op(op_c), .tc(tc_c), .ovf(ovf_c));
   updn_ctr_p #(.WIDTH(8), .MAX(255), .SAT(1'b0)) u_d (.clk(clk), .rst(rst), .cn(cn), .ct(ct),
      .clr(clr), .ld(ld), .din(din),      .op(op_d), .tc(tc_d), .ovf(ovf_d));
   updn_ctr_p #(.WIDTH(8), .MAX(200), .SAT(1'b1)) u_e (.clk(clk), .rst(rst), .cn(cn), .ct(ct),
      .clr(clr), .ld(ld), .din(din),      .op(op_e), .tc(tc_e), .ovf(ovf_e));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      int op;
      bit tc;
      bit ovf;
   } mst_t;

   mst_t ms[5];

   typedef struct {
      int    seg;
      int    dut;
      bit    cn, ct, clr, ld;
      int    din;
      int    e_op;
      bit    e_tc, e_ovf;
      string name;
   } vec_t;

   vec_t vecs[$];

   function automatic int dut_max(int d);
      case (d)
         0: return 31;
         1: return 9;
         2: return 9;
         3: return 255;
         default: return 200;
      endcase
   endfunction

   function automatic bit dut_sat(int d);
      return (d == 1) || (d == 4);
   endfunction

   function automatic int dut_mask(int d);
      return (d <= 2) ? 31 : 255;
   endfunction

   function automatic logic [31:0] get_op(int d);
      case (d)
         0: return 32'(op_a);
         1: return 32'(op_b);
         2: return 32'(op_c);
         3: return 32'(op_d);
         default: return 32'(op_e);
      endcase
   endfunction

   function automatic logic [31:0] get_tc(int d);
      case (d)
         0: return 32'(tc_a);
         1: return 32'(tc_b);
         2: return 32'(tc_c);
         3: return 32'(tc_d);
         default: return 32'(tc_e);
      endcase
   endfunction

   function automatic logic [31:0] get_ovf(int d);
      case (d)
         0: return 32'(ovf_a);
         1: return 32'(ovf_b);
         2: return 32'(ovf_c);
         3: return 32'(ovf_d);
         default: return 32'(ovf_e);
      endcase
   endfunction

   // Reference behaviour of one counter over one rising edge.
   function automatic mst_t mnext(mst_t s, int mx, bit sat, bit i_cn, bit i_ct,
                                  bit i_clr, bit i_ld, int i_din);
      mst_t n;
      n    = s;
      n.tc = 1'b0;
      if (i_clr) begin
         n.op  = 0;
         n.ovf = 1'b0;
      end else if (i_ld) begin
         n.op = (i_din > mx) ? mx : i_din;
      end else if (i_cn) begin
         if (!i_ct) begin
            if (s.op < mx) n.op = s.op + 1;
            else begin
               n.op  = sat ? mx : 0;
               n.tc  = 1'b1;
               n.ovf = 1'b1;
            end
         end else begin
            if (s.op > 0) n.op = s.op - 1;
            else begin
               n.op  = sat ? 0 : mx;
               n.tc  = 1'b1;
               n.ovf = 1'b1;
            end
         end
      end
      return n;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(string name, int d, int e_op, bit e_tc, bit e_ovf);
      check({name, ".op"},  get_op(d),  32'(e_op));
      check({name, ".tc"},  get_tc(d),  32'(e_tc));
      check({name, ".ovf"}, get_ovf(d), 32'(e_ovf));
   endtask

   // Drive on the falling edge, let the rising edge happen, sample 1 ns later.
   task automatic step(bit a_cn, bit a_ct, bit a_clr, bit a_ld, int a_din);
      @(negedge clk);
      cn  = a_cn;
      ct  = a_ct;
      clr = a_clr;
      ld  = a_ld;
      din = a_din[7:0];
      @(posedge clk);
      if (rst) begin
         for (int d = 0; d < 5; d++)
            ms[d] = mnext(ms[d], dut_max(d), dut_sat(d), cn, ct, clr, ld,
                          int'(din) & dut_mask(d));
      end
      #1;
   endtask

   function automatic void add(int seg, int dut, bit a_cn, bit a_ct, bit a_clr, bit a_ld,
                               int a_din, int e_op, bit e_tc, bit e_ovf, string name);
      vec_t v;
      v.seg = seg;  v.dut = dut;
      v.cn = a_cn;  v.ct = a_ct;  v.clr = a_clr;  v.ld = a_ld;  v.din = a_din;
      v.e_op = e_op;  v.e_tc = e_tc;  v.e_ovf = e_ovf;  v.name = name;
      vecs.push_back(v);
   endfunction

   task automatic run_seg(int seg);
      foreach (vecs[i]) begin
         if (vecs[i].seg == seg) begin
            step(vecs[i].cn, vecs[i].ct, vecs[i].clr, vecs[i].ld, vecs[i].din);
            check_dut($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].dut,
                      vecs[i].e_op, vecs[i].e_tc, vecs[i].e_ovf);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 5; d++) ms[d] = '{op: 0, tc: 1'b0, ovf: 1'b0};

      // seg 1: dut a, load 4 then down 6, then reverse up 2
      add(1, 0, 0, 0, 0, 1,  4,  4, 0, 1, "a_ld4");
      add(1, 0, 1, 1, 0, 0,  0,  3, 0, 1, "a_dn");
      add(1, 0, 1, 1, 0, 0,  0,  2, 0, 1, "a_dn");
      add(1, 0, 1, 1, 0, 0,  0,  1, 0, 1, "a_dn");
      add(1, 0, 1, 1, 0, 0,  0,  0, 0, 1, "a_dn");
      add(1, 0, 1, 1, 0, 0,  0, 31, 1, 1, "a_dn_wrap");
      add(1, 0, 1, 1, 0, 0,  0, 30, 0, 1, "a_dn");
      add(1, 0, 1, 0, 0, 0,  0, 31, 0, 1, "a_rev_up");
      add(1, 0, 1, 0, 0, 0,  0,  0, 1, 1, "a_up_wrap");
      // seg 2: dut b (mod 10, saturate)
      add(2, 1, 0, 0, 1, 0,  0,  0, 0, 0, "b_clr");
      add(2, 1, 0, 0, 0, 1,  7,  7, 0, 0, "b_ld7");
      add(2, 1, 1, 0, 0, 0,  0,  8, 0, 0, "b_up");
      add(2, 1, 1, 0, 0, 0,  0,  9, 0, 0, "b_up");
      add(2, 1, 1, 0, 0, 0,  0,  9, 1, 1, "b_sat_hi");
      add(2, 1, 1, 0, 0, 0,  0,  9, 1, 1, "b_sat_hi");
      add(2, 1, 1, 0, 0, 0,  0,  9, 1, 1, "b_sat_hi");
      for (int k = 8; k >= 0; k--) add(2, 1, 1, 1, 0, 0, 0, k, 0, 1, "b_dn");
      add(2, 1, 1, 1, 0, 0,  0,  0, 1, 1, "b_sat_lo");
      add(2, 1, 1, 1, 0, 0,  0,  0, 1, 1, "b_sat_lo");
      add(2, 1, 1, 1, 0, 0,  0,  0, 1, 1, "b_sat_lo");
      // seg 3: dut c (mod 10, wrap): clamp, priorities, sticky ovf
      add(3, 2, 0, 0, 1, 0,  0,  0, 0, 0, "c_clr");
      add(3, 2, 0, 0, 0, 1, 13,  9, 0, 0, "c_ld_clamp");
      add(3, 2, 1, 0, 0, 1,  3,  3, 0, 0, "c_ld_over_cn");
      add(3, 2, 0, 0, 0, 1,  9,  9, 0, 0, "c_ld_max");
      add(3, 2, 1, 0, 0, 0,  0,  0, 1, 1, "c_up_wrap");
      add(3, 2, 0, 0, 0, 1,  2,  2, 0, 1, "c_ld_keeps_ovf");
      add(3, 2, 0, 0, 0, 0,  0,  2, 0, 1, "c_hold");
      add(3, 2, 1, 0, 1, 1,  5,  0, 0, 0, "c_clr_over_ld");
      add(3, 2, 1, 1, 0, 0,  0,  9, 1, 1, "c_dn_wrap");
      add(3, 2, 1, 0, 0, 0,  0,  0, 1, 1, "c_up_wrap2");

      cn = 1'b0; ct = 1'b0; clr = 1'b0; ld = 1'b0; din = '0;
      rst = 1'b1;
      #3 rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 5; d++) check_dut($sformatf("reset_dut%0d", d), d, 0, 0, 0);
      rst = 1'b1;

      // Basic count on dut a: 0..31, then 0, then 1
      for (int k = 0; k < 33; k++) begin
         step(1, 0, 0, 0, 0);
         check_dut($sformatf("a_count%0d", k), 0, (k + 1) % 32, k == 31, k >= 31);
      end

      run_seg(1);
      run_seg(2);
      run_seg(3);

      // Asynchronous reset mid-count on dut a at op=17 with ovf set
      step(0, 0, 0, 1, 31);
      step(1, 0, 0, 0, 0);
      check_dut("a_pre_wrap", 0, 0, 1, 1);
      for (int k = 0; k < 17; k++) step(1, 0, 0, 0, 0);
      check_dut("a_at17", 0, 17, 0, 1);
      #1 rst = 1'b0;
      for (int d = 0; d < 5; d++) ms[d] = '{op: 0, tc: 1'b0, ovf: 1'b0};
      #1 check_dut("a_async_rst", 0, 0, 0, 0);
      #2 rst = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step(1, 0, 0, 0, 0);
         check_dut($sformatf("a_resume%0d", k), 0, k, 0, 0);
      end

      // Random regression of all instances against the reference model
      for (int cyc = 0; cyc < 2000; cyc++) begin
         step($urandom_range(0, 99) < 80, $urandom_range(0, 1) == 1,
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8,
              int'($urandom_range(0, 255)));
         for (int d = 0; d < 5; d++)
            check_dut($sformatf("rnd%0d_dut%0d", cyc, d), d, ms[d].op, ms[d].tc, ms[d].ovf);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
